// File: rtl/spi_write_sequencer.sv
// ============================================================================
// spi_write_sequencer
// ----------------------------------------------------------------------------
// Serialises queued register commands into 16-bit SPI mode-0 frames
// {write, addr[6:0], data[7:0]} on SCLK/COPI/nCS. Commands are buffered in a
// first-word-fall-through FIFO. SCLK is paced from clk, and nCS is held high
// between frames so the peripheral can commit each frame.
//
// Parameters:
//   CLK_DIV    system clocks per SCLK half-period (2..255)
//   FIFO_DEPTH command FIFO entries, power of two (2..16)
//   CS_GAP     minimum clocks nCS stays high between frames (1..255)
//   MAX_ADDR   highest address a write command may target
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   cmd_valid    command offered
//   cmd_ready    command accepted when cmd_valid && cmd_ready
//   cmd_write    1 = write frame, 0 = read frame (data sent as 0x00)
//   cmd_addr     register address
//   cmd_data     write data
//   cmd_err      one-cycle pulse: write to an address above MAX_ADDR dropped
//   SCLK         SPI clock, idles low
//   COPI         serial data, MSB first
//   nCS          chip select, active low
//   busy         FIFO non-empty or a frame/gap in progress
//   frames_sent  completed frame count, wraps at 255
//
// Optional build macro:
//   SPI_SEQ_INIT_EN  after reset, write 0x00 to addresses 0..MAX_ADDR before
//                    accepting commands.
// ============================================================================
module spi_write_sequencer #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CS_GAP     = 8,
    parameter int unsigned MAX_ADDR   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       cmd_err,
    output logic       SCLK,
    output logic       COPI,
    output logic       nCS,
    output logic       busy,
    output logic [7:0] frames_sent
);

    localparam int unsigned HW = $clog2(CLK_DIV + 1);
    localparam int unsigned GW = $clog2(CS_GAP + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [HW-1:0] HALF_RELOAD = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_RELOAD  = GW'(CS_GAP - 1);
    localparam logic [PW-1:0] FULL_COUNT  = PW'(FIFO_DEPTH);
    localparam logic [6:0]    ADDR_MAX    = 7'(MAX_ADDR);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    // State and output registers
    logic [2:0]    r_state;
    logic [HW-1:0] r_half;
    logic [GW-1:0] r_gap;
    logic [3:0]    r_bit;
    logic [15:0]   r_shift;
    logic          r_sclk;
    logic          r_copi;
    logic          r_ncs;
    logic [7:0]    r_frames;
    logic          r_busy;
    logic          r_err;
    logic          r_ready;

    // FIFO storage and wrap-bit pointers
    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;

    // Next-state and decode wires
    logic [2:0]    w_state_nxt;
    logic [HW-1:0] w_half_nxt;
    logic [GW-1:0] w_gap_nxt;
    logic [3:0]    w_bit_nxt;
    logic [15:0]   w_shift_nxt;
    logic          w_sclk_nxt;
    logic          w_copi_nxt;
    logic          w_ncs_nxt;
    logic [7:0]    w_frames_nxt;
    logic          w_busy_nxt;
    logic          w_ready_nxt;

    logic          w_hs;
    logic          w_reject;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic [15:0]   w_head;
    logic [15:0]   w_frame_in;
    logic [15:0]   w_load_frame;
    logic [PW-1:0] w_wr_nxt;
    logic [PW-1:0] w_rd_nxt;
    logic [PW-1:0] w_count_nxt;

    logic          w_init_pending;
    logic          w_init_active_nxt;
    logic [15:0]   w_init_frame;

`ifdef SPI_SEQ_INIT_EN
    localparam logic READY_RST = 1'b0;

    logic       r_init_active;
    logic [6:0] r_init_addr;
    logic       w_init_step;

    // An init frame is retired when its gap finishes
    assign w_init_step = (r_state == ST_GAP) && (r_gap == '0);

    // Init sequence: one zero-write per address, ascending
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_init_active <= 1'b1;
            r_init_addr   <= '0;
        end else if (w_init_step && r_init_active) begin
            if (r_init_addr == ADDR_MAX) begin
                r_init_active <= 1'b0;
            end else begin
                r_init_addr <= r_init_addr + 7'd1;
            end
        end
    end

    assign w_init_pending    = r_init_active;
    assign w_init_frame      = {1'b1, r_init_addr, 8'h00};
    assign w_init_active_nxt = r_init_active &&
                               !(w_init_step && (r_init_addr == ADDR_MAX));
`else
    localparam logic READY_RST = 1'b1;

    assign w_init_pending    = 1'b0;
    assign w_init_frame      = 16'h0000;
    assign w_init_active_nxt = 1'b0;
`endif

    // Input handshake: out-of-range writes are consumed but never queued
    assign w_hs       = cmd_valid && r_ready;
    assign w_reject   = w_hs && cmd_write && (cmd_addr > ADDR_MAX);
    assign w_push     = w_hs && !w_reject;
    assign w_frame_in = {cmd_write, cmd_addr, (cmd_write ? cmd_data : 8'h00)};

    // FIFO status and pointer update
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_head       = r_mem[r_rd_ptr[AW-1:0]];
    assign w_load_frame = w_init_pending ? w_init_frame : w_head;
    assign w_wr_nxt     = w_push ? (r_wr_ptr + PW'(1)) : r_wr_ptr;
    assign w_rd_nxt     = w_pop  ? (r_rd_ptr + PW'(1)) : r_rd_ptr;
    assign w_count_nxt  = w_wr_nxt - w_rd_nxt;

    // Status outputs registered from next-cycle occupancy and state
    assign w_busy_nxt  = (w_count_nxt != '0) || (w_state_nxt != ST_IDLE) ||
                         w_init_active_nxt;
    assign w_ready_nxt = (w_count_nxt != FULL_COUNT) && !w_init_active_nxt;

    // Frame sequencing and pin generation
    always_comb begin
        w_state_nxt  = r_state;
        w_half_nxt   = r_half;
        w_gap_nxt    = r_gap;
        w_bit_nxt    = r_bit;
        w_shift_nxt  = r_shift;
        w_sclk_nxt   = r_sclk;
        w_copi_nxt   = r_copi;
        w_ncs_nxt    = r_ncs;
        w_frames_nxt = r_frames;
        w_pop        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_init_pending || !w_empty) begin
                    w_pop       = !w_init_pending;
                    w_shift_nxt = w_load_frame;
                    w_state_nxt = ST_SETUP;
                    w_half_nxt  = HALF_RELOAD;
                    w_ncs_nxt   = 1'b0;
                    w_sclk_nxt  = 1'b0;
                    w_copi_nxt  = w_load_frame[15];
                end
            end

            ST_SETUP: begin
                if (r_half == '0) begin
                    w_state_nxt = ST_SHIFT;
                    w_half_nxt  = HALF_RELOAD;
                    w_sclk_nxt  = 1'b1;
                    w_bit_nxt   = 4'd15;
                end else begin
                    w_half_nxt = r_half - HW'(1);
                end
            end

            ST_SHIFT: begin
                if (r_half != '0) begin
                    w_half_nxt = r_half - HW'(1);
                end else if (r_sclk) begin
                    // Falling edge: present the next bit. Zeros shift in, so
                    // the fall after bit 0 drives COPI low for HOLD.
                    w_sclk_nxt  = 1'b0;
                    w_half_nxt  = HALF_RELOAD;
                    w_shift_nxt = {r_shift[14:0], 1'b0};
                    w_copi_nxt  = r_shift[14];
                end else if (r_bit == 4'd0) begin
                    w_state_nxt = ST_HOLD;
                    w_half_nxt  = HALF_RELOAD;
                    w_copi_nxt  = 1'b0;
                end else begin
                    w_bit_nxt  = r_bit - 4'd1;
                    w_sclk_nxt = 1'b1;
                    w_half_nxt = HALF_RELOAD;
                end
            end

            ST_HOLD: begin
                if (r_half == '0) begin
                    w_state_nxt  = ST_GAP;
                    w_gap_nxt    = GAP_RELOAD;
                    w_ncs_nxt    = 1'b1;
                    w_sclk_nxt   = 1'b0;
                    w_copi_nxt   = 1'b0;
                    w_frames_nxt = r_frames + 8'd1;
                end else begin
                    w_half_nxt = r_half - HW'(1);
                end
            end

            ST_GAP: begin
                if (r_gap == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap - GW'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_ncs_nxt   = 1'b1;
                w_sclk_nxt  = 1'b0;
                w_copi_nxt  = 1'b0;
            end
        endcase
    end

    // State, pointer and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_half   <= '0;
            r_gap    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_sclk   <= 1'b0;
            r_copi   <= 1'b0;
            r_ncs    <= 1'b1;
            r_frames <= '0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_ready  <= READY_RST;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_half   <= w_half_nxt;
            r_gap    <= w_gap_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_sclk   <= w_sclk_nxt;
            r_copi   <= w_copi_nxt;
            r_ncs    <= w_ncs_nxt;
            r_frames <= w_frames_nxt;
            r_busy   <= w_busy_nxt;
            r_err    <= w_reject;
            r_ready  <= w_ready_nxt;
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_frame_in;
        end
    end

    assign cmd_ready   = r_ready;
    assign cmd_err     = r_err;
    assign SCLK        = r_sclk;
    assign COPI        = r_copi;
    assign nCS         = r_ncs;
    assign busy        = r_busy;
    assign frames_sent = r_frames;

endmodule

// File: tb/tb_spi_write_sequencer.sv
// ============================================================================
// tb_spi_write_sequencer
// ----------------------------------------------------------------------------
// Directed bench for spi_write_sequencer (CLK_DIV=4, FIFO_DEPTH=4, CS_GAP=8,
// MAX_ADDR=4). A pin monitor rebuilds each frame from COPI at SCLK rises and
// records nCS-low length, rise count and the nCS-high gap between frames.
// Honours SPI_SEQ_INIT_EN for the post-reset init frames.
// ============================================================================
module tb_spi_write_sequencer;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned CS_GAP  = 8;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic [6:0] cmd_addr  = '0;
    logic [7:0] cmd_data  = '0;
    logic       cmd_ready;
    logic       cmd_err;
    logic       SCLK;
    logic       COPI;
    logic       nCS;
    logic       busy;
    logic [7:0] frames_sent;

    spi_write_sequencer #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (4),
        .CS_GAP     (CS_GAP),
        .MAX_ADDR   (4)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_err     (cmd_err),
        .SCLK        (SCLK),
        .COPI        (COPI),
        .nCS         (nCS),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pin monitor, sampled on the falling clk edge
    logic [15:0] mon_frames [$];
    int          mon_lens   [$];
    int          mon_rises  [$];
    logic [15:0] cur_sh    = '0;
    int          cur_rises = 0;
    int          cur_len   = 0;
    int          gap_len   = 0;
    int          min_gap   = 1000;
    int          ncs_falls = 0;
    int          copi_viol = 0;
    bit          seen      = 1'b0;
    logic        p_ncs     = 1'b1;
    logic        p_sclk    = 1'b0;
    logic        p_copi    = 1'b0;

    always @(negedge clk) begin
        if (nCS === 1'b0) begin
            if (p_ncs === 1'b1) begin
                cur_sh    = '0;
                cur_rises = 0;
                cur_len   = 0;
                ncs_falls++;
                if (seen && gap_len < min_gap) min_gap = gap_len;
            end else if ((COPI !== p_copi) && !(p_sclk === 1'b1 && SCLK === 1'b0)) begin
                copi_viol++;
            end
            cur_len++;
            if (SCLK === 1'b1 && p_sclk === 1'b0) begin
                cur_rises++;
                cur_sh = {cur_sh[14:0], COPI};
            end
        end else begin
            if (p_ncs === 1'b0) begin
                mon_frames.push_back(cur_sh);
                mon_lens.push_back(cur_len);
                mon_rises.push_back(cur_rises);
                seen    = 1'b1;
                gap_len = 0;
            end
            gap_len++;
        end
        p_ncs  = nCS;
        p_sclk = SCLK;
        p_copi = COPI;
    end

    task automatic clear_mon();
        mon_frames.delete();
        mon_lens.delete();
        mon_rises.delete();
    endtask

    // Offer one command starting at a falling edge; returns on the falling
    // edge after the handshake
    task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        cmd_write = w;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("send_ready_timeout", cmd_ready, 1);
        end else begin
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic check_frame(input string tag, input int idx, input logic [15:0] exp);
        if (idx < mon_frames.size()) begin
            check({tag, "_data"},  mon_frames[idx], exp);
            check({tag, "_len"},   mon_lens[idx],   CLK_DIV * 34);
            check({tag, "_rises"}, mon_rises[idx],  16);
        end else begin
            check({tag, "_missing"}, mon_frames.size(), idx + 1);
        end
    endtask

`ifdef SPI_SEQ_INIT_EN
    task automatic check_init_frames(input string tag);
        repeat (2) @(negedge clk);
        wait_idle(4000, tag);
        check({tag, "_count"}, mon_frames.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check_frame(tag, i, {1'b1, 7'(i), 8'h00});
        end
        check({tag, "_fs"}, frames_sent, 5);
        clear_mon();
    endtask
`endif

    initial begin
        int exp_fs;
        int hs;
        int budget;
        int falls0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ncs",    nCS, 1);
        check("rst_sclk",   SCLK, 0);
        check("rst_copi",   COPI, 0);
        check("rst_busy",   busy, 0);
        check("rst_err",    cmd_err, 0);
        check("rst_frames", frames_sent, 0);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef SPI_SEQ_INIT_EN
        check("rst_ready", cmd_ready, 0);
        check_init_frames("init");
        exp_fs = 5;
`else
        check("rst_ready", cmd_ready, 1);
        exp_fs = 0;
`endif

        // Single write: addr 2, data 0xA5
        clear_mon();
        send(1'b1, 7'd2, 8'hA5);
        check("t1_busy", busy, 1);
        wait_idle(1000, "t1");
        check("t1_count", mon_frames.size(), 1);
        check_frame("t1", 0, 16'h82A5);
        exp_fs += 1;
        check("t1_fs", frames_sent, 8'(exp_fs));

        // Three back-to-back writes, including the highest legal address
        clear_mon();
        min_gap = 1000;
        send(1'b1, 7'd0, 8'h11);
        send(1'b1, 7'd1, 8'h22);
        send(1'b1, 7'd4, 8'h80);
        check("t2_err", cmd_err, 0);
        check("t2_busy", busy, 1);
        wait_idle(3000, "t2");
        check("t2_count", mon_frames.size(), 3);
        check_frame("t2a", 0, 16'h8011);
        check_frame("t2b", 1, 16'h8122);
        check_frame("t2c", 2, 16'h8480);
        check("t2_gap_ok", (min_gap >= CS_GAP), 1);
        exp_fs += 3;
        check("t2_fs", frames_sent, 8'(exp_fs));

        // Capacity: ten writes offered back to back with cmd_valid held high
        clear_mon();
        hs        = 0;
        cmd_write = 1'b1;
        cmd_addr  = 7'd0;
        cmd_data  = 8'h30;
        cmd_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (cmd_ready) begin
                @(negedge clk);
                hs++;
                cmd_addr = 7'(hs % 5);
                cmd_data = 8'(8'h30 + hs);
            end else begin
                @(negedge clk);
            end
        end
        check("t3_hs_full", hs, 5);
        check("t3_ready_low", cmd_ready, 0);
        budget = 0;
        while (hs < 10 && budget < 3000) begin
            if (cmd_ready) begin
                if (hs == 5) begin
                    check("t3_reopen_ncs", nCS, 0);
                    check("t3_reopen_fs", frames_sent, 8'(exp_fs + 1));
                end
                @(negedge clk);
                hs++;
                cmd_addr = 7'(hs % 5);
                cmd_data = 8'(8'h30 + hs);
            end else begin
                @(negedge clk);
            end
            budget++;
        end
        cmd_valid = 1'b0;
        check("t3_hs_total", hs, 10);
        wait_idle(4000, "t3");
        check("t3_count", mon_frames.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < mon_frames.size()) begin
                check($sformatf("t3_frame%0d", i), mon_frames[i],
                      {1'b1, 7'(i % 5), 8'(8'h30 + i)});
            end
        end
        exp_fs += 10;
        check("t3_fs", frames_sent, 8'(exp_fs));

        // Write above MAX_ADDR: consumed, flagged, never sent
        falls0 = ncs_falls;
        send(1'b1, 7'd5, 8'h55);
        check("t4_err_pulse", cmd_err, 1);
        check("t4_busy", busy, 0);
        @(negedge clk);
        check("t4_err_clear", cmd_err, 0);
        repeat (20) @(negedge clk);
        check("t4_no_frame", ncs_falls, falls0);
        check("t4_fs", frames_sent, 8'(exp_fs));

        // Reads: data forced to zero, high addresses still accepted
        clear_mon();
        send(1'b0, 7'd3, 8'hFF);
        check("t5_err_a", cmd_err, 0);
        send(1'b0, 7'h7F, 8'h12);
        check("t5_err_b", cmd_err, 0);
        wait_idle(2000, "t5");
        check("t5_count", mon_frames.size(), 2);
        check_frame("t5a", 0, 16'h0300);
        check_frame("t5b", 1, 16'h7F00);
        exp_fs += 2;
        check("t5_fs", frames_sent, 8'(exp_fs));

        // Reset at bit 7 with two commands queued
        clear_mon();
        send(1'b1, 7'd0, 8'h01);
        send(1'b1, 7'd1, 8'h02);
        send(1'b1, 7'd2, 8'h03);
        budget = 0;
        while (!(nCS === 1'b0 && cur_rises == 9) && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        check("t6_reached_bit7", cur_rises, 9);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_ncs", nCS, 1);
        check("t6_sclk", SCLK, 0);
        check("t6_copi", COPI, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        falls0 = ncs_falls;
`ifdef SPI_SEQ_INIT_EN
        check_init_frames("t6_init");
`else
        check("t6_ready", cmd_ready, 1);
        repeat (300) @(negedge clk);
        check("t6_no_frames", ncs_falls, falls0);
        check("t6_fs", frames_sent, 0);
        check("t6_busy", busy, 0);
`endif

        check("copi_stability", copi_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
